bit_serializer: RTL and testbench

Parallel-to-serial stage that sits directly upstream of the Moore pattern detector and drives its serial `in` input one bit per clock. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out over exactly WIDTH cycles. A qualifying valid flag and an end-of-word pulse go with the bit stream. Words can be chained back-to-back with no idle gap, so the detector sees a continuous stream across word boundaries.

---
 rtl/bit_serializer_if.sv | 22 ++
 rtl/bit_serializer.sv | 115 +++++++++++
 tb/tb_bit_serializer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Load/stream bundle for the bit serializer: word handshake in, serial bit stream out.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             flush;
  logic             out;
  logic             out_valid;
  logic             done;

  modport master (
    output data_in, load_valid, flush,
    input  load_ready, out, out_valid, done
  );

  modport slave (
    input  data_in, load_valid, flush,
    output load_ready, out, out_valid, done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: shifts a WIDTH-bit word out one bit per clock,
// allowing the next word to be chained in the last-bit cycle with no gap.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic             clk,
  input logic             reset,
  bit_serializer_if.slave bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             out_r, out_s;
  logic             out_valid_r, out_valid_s;
  logic             done_r, done_s;
  logic             load_ready_s;
  logic             accept_s;

  assign load_ready_s = (state_r == IDLE) || ((state_r == SHIFT) && (cnt_r == LAST));
  assign accept_s     = bus.load_valid && load_ready_s && !bus.flush;

  assign bus.load_ready = load_ready_s;
  assign bus.out        = out_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.done       = done_r;

  // Next-state logic; out/out_valid are derived from the next state so the registered
  // bit always reflects the word position being presented in the following cycle.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shreg_s = bus.data_in;
          cnt_s   = {CW{1'b0}};
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r != LAST) begin
          cnt_s = cnt_r + CW'(1);
          if (MSB_FIRST) begin
            shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
          end else begin
            shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
          end
        end else if (accept_s) begin
          shreg_s = bus.data_in;
          cnt_s   = {CW{1'b0}};
          done_s  = 1'b1;
        end else begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
          done_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase

    // An aborted word is dropped without a done pulse, and any same-cycle load is lost.
    if (bus.flush) begin
      state_s = IDLE;
      cnt_s   = {CW{1'b0}};
      shreg_s = {WIDTH{1'b0}};
      done_s  = 1'b0;
    end else begin
      state_s = state_s;
    end

    if (state_s == SHIFT) begin
      out_valid_s = 1'b1;
      out_s       = MSB_FIRST ? shreg_s[WIDTH-1] : shreg_s[0];
    end else begin
      out_valid_s = 1'b0;
      out_s       = IDLE_BIT;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_r       <= IDLE_BIT;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      cnt_r       <= cnt_s;
      out_r       <= out_s;
      out_valid_r <= out_valid_s;
      done_r      <= done_s;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: an MSB-first/idle-0 and an LSB-first/idle-1 serializer driven in lockstep.
module tb_bit_serializer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) ifa ();
  bit_serializer_if #(.WIDTH(8)) ifb ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  typedef struct packed {
    logic ba;
    logic bb;
    logic last;
  } ent_t;

  ent_t exp_q[$];
  logic prev_last = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, check ready, update scoreboard, then check the outputs.
  task automatic cycle(input logic lv, input logic [7:0] d, input logic fl, input logic rs);
    logic acc;
    logic exp_done;
    ent_t e;
    reset          = rs;
    ifa.load_valid = lv;
    ifa.data_in    = d;
    ifa.flush      = fl;
    ifb.load_valid = lv;
    ifb.data_in    = d;
    ifb.flush      = fl;
    #1;
    check("ready_a", ifa.load_ready, exp_q.size() == 0);
    check("ready_b", ifb.load_ready, exp_q.size() == 0);
    acc = rs && !fl && lv && (exp_q.size() == 0);
    if (!rs || fl) begin
      exp_q.delete();
      prev_last = 1'b0;
    end
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        e.ba   = d[7-i];
        e.bb   = d[i];
        e.last = (i == 7);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    exp_done = prev_last;
    check("done_a", ifa.done, exp_done);
    check("done_b", ifb.done, exp_done);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid_a", ifa.out_valid, 1'b1);
      check("valid_b", ifb.out_valid, 1'b1);
      check("out_a", ifa.out, e.ba);
      check("out_b", ifb.out, e.bb);
      prev_last = e.last;
    end else begin
      check("valid_a", ifa.out_valid, 1'b0);
      check("valid_b", ifb.out_valid, 1'b0);
      check("idle_a", ifa.out, 1'b0);
      check("idle_b", ifb.out, 1'b1);
      prev_last = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    reset          = 1'b0;
    ifa.load_valid = 1'b0;
    ifa.data_in    = 8'h00;
    ifa.flush      = 1'b0;
    ifb.load_valid = 1'b0;
    ifb.data_in    = 8'h00;
    ifb.flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_a", ifa.out, 1'b0);
    check("rst_out_b", ifb.out, 1'b1);
    check("rst_valid", ifa.out_valid, 1'b0);
    check("rst_done", ifa.done, 1'b0);
    idle(2);

    // Single word
    cycle(1'b1, 8'hB2, 1'b0, 1'b1);
    idle(11);

    // Back-to-back: 4D held until the last-bit cycle accepts it
    cycle(1'b1, 8'hB2, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h4D, 1'b0, 1'b1);
    idle(11);

    // Load while busy is ignored
    cycle(1'b1, 8'hB2, 1'b0, 1'b1);
    idle(3);
    cycle(1'b1, 8'hFF, 1'b0, 1'b1);
    idle(12);

    // Reset mid-word, then a clean word
    cycle(1'b1, 8'hB2, 1'b0, 1'b1);
    idle(4);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 8'h81, 1'b0, 1'b1);
    idle(11);

    // Flush with a simultaneous load
    cycle(1'b1, 8'hB2, 1'b0, 1'b1);
    idle(5);
    cycle(1'b1, 8'h4D, 1'b1, 1'b1);
    idle(4);

    // Flush in the last-bit cycle suppresses done
    cycle(1'b1, 8'h5A, 1'b0, 1'b1);
    idle(7);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
